l15_resp_serializer: RTL and testbench
======================================

# l15_resp_serializer

Parametrised response serializer between the L1.5 and a narrow-bus transducer. It accepts whole L1.5 responses with a line-wide data field, selected by `LINE_BYTES`, into a small response FIFO. It replays each response as `BEAT_BITS` beats over a valid/ready channel. This decouples the L1.5 line size from the core-side bus width, and it adds back-pressure buffering and optional critical-word-first ordering.

## Interface
Parameters:
- `LINE_BYTES`, default 64: L1D line size in bytes.
- `BEAT_BITS`, default 64: output beat width.
- `FIFO_DEPTH`, default 2: buffered responses; power of two, at least 2.
- Derived `NUM_BEATS` = `LINE_BYTES`*8/`BEAT_BITS`: power of two, at least 1. `BEAT_IDX_W` = max(1, log2(`NUM_BEATS`)).

Ports:
- `clk`  in  1  clock. Single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `l15_resp_val`  in  1  response valid; held by the L1.5 until acked.
- `l15_resp_rtntype`  in  4  return type.
- `l15_resp_threadid`  in  1  thread id.
- `l15_resp_multi`  in  1  1 = full-line response (`NUM_BEATS` beats); 0 = single beat (bits [`BEAT_BITS`-1:0]).
- `l15_resp_first_beat`  in  `BEAT_IDX_W`  critical beat index.
- `l15_resp_data`  in  `LINE_BYTES`*8  line data; beat k = bits [k*`BEAT_BITS` +: `BEAT_BITS`].
- `l15_resp_ack`  out  1  accept strobe. Combinational: `l15_resp_val` && !full.
- `beat_val`  out  1  beat valid.
- `beat_rdy`  in  1  consumer ready.
- `beat_data`  out  `BEAT_BITS`  beat payload.
- `beat_idx`  out  `BEAT_IDX_W`  line position of this beat.
- `beat_first` / `beat_last`  out  1 each  first/last beat of a response.
- `beat_rtntype`  out  4  copied from head entry.
- `beat_threadid`  out  1  copied from head entry.
- `occupancy`  out  log2(`FIFO_DEPTH`)+1  entries stored.

## Operation
- Enqueue:
  - When `l15_resp_ack` is high, the whole response is written to the FIFO tail at the clock edge.
  - Full blocks ack.
  - No same-cycle pass-through when full, even if the head pops that cycle.
- Output:
  - `beat_val` = FIFO not empty.
  - The head entry is presented beat by beat under beat counter `cnt`, where 0 ≤ `cnt` < (multi ? `NUM_BEATS` : 1).
- Handshake:
  - On `beat_val` && `beat_rdy`, `cnt` increments.
  - On `beat_last`, `cnt` returns to 0 and the head pops.
  - Once `beat_val` is high, it and all beat fields hold stable until the handshake.
- Index:
  - Without CWF (see Configuration): `beat_idx` = `cnt`.
  - Single-beat entries: `beat_idx` = 0, and `beat_first` = `beat_last` = 1.
- Flags: `beat_first` = (`cnt` == 0). `beat_last` = (`cnt` == last).
- Pointers:
  - Read and write pointers are log2(`FIFO_DEPTH`)+1 bits and wrap naturally.
  - Full = MSBs differ and LSBs are equal.
- Simultaneous enqueue and pop (not full) leaves `occupancy` unchanged.
- Reset:
  - Asserting `rst_n` low mid-response discards the partial entry and all queued entries.
  - No further beats are emitted for them.

## Timing
- Reset values:
  - `beat_val` = 0, `occupancy` = 0, `cnt` = 0, pointers = 0.
  - `l15_resp_ack` follows `l15_resp_val` (the FIFO is empty).
  - Beat data/fields are don't-care while `beat_val` = 0; the implementation drives 0.
- Latency: a response acked in cycle N has its first beat with `beat_val` high in cycle N+1 (storage is registered).
- Throughput: one beat per cycle with `beat_rdy` held high. Back-to-back responses have no bubble between the last beat of one and the first beat of the next.
- A full-line response with continuous ready occupies the output for `NUM_BEATS` consecutive cycles.

## Configuration
- Macro `L15_RESP_SER_CWF_EN`:
  - Defined: `beat_idx` = (`l15_resp_first_beat` + `cnt`) mod `NUM_BEATS` for multi entries, i.e. critical-word-first with wrap-around. `l15_resp_first_beat` is stored per entry.
  - Undefined: the `l15_resp_first_beat` port remains, but it is not stored and is ignored. Order is always 0..`NUM_BEATS`-1.
- Single-beat entries are unaffected in both modes.

## Structure
- Shared package `l15_resp_ser_pkg` holds:
  - the entry struct type (rtntype, threadid, multi, first_beat, data);
  - the derived widths `NUM_BEATS` and `BEAT_IDX_W`;
  - an elaboration-time check function for the parameter legality rules.
- One sub-module, `l15_resp_ser_fifo`: a parametrised synchronous FIFO that holds entry storage, pointers, full/empty and occupancy.
- The top level holds the beat counter, beat mux and handshake logic.

## Test plan
- **Reset, then one line response.** Stimulus: `LINE_BYTES`=64, `BEAT_BITS`=64, multi=1, data beat k = 0x1111_1111_1111_1111*k, `beat_rdy`=1. Expected: ack in cycle N; beats idx 0..7 in cycles N+1..N+8 with matching data; `beat_first` high only at idx 0, `beat_last` high only at idx 7.
- **Back-pressure.** Stimulus: `beat_rdy` toggles 1,0,0,1. Expected: beat fields stay stable while stalled; no beat is lost or duplicated; 8 handshakes total.
- **Full FIFO.** Stimulus: `FIFO_DEPTH`=2, `beat_rdy`=0, three responses. Expected: acks for the first two; the third is held unacked; `occupancy`=2. Its ack rises only in the cycle after the head pops.
- **Single-beat response.** Stimulus: multi=0, rtntype=4'h4, data[63:0]=0xDEAD_BEEF. Expected: exactly one beat with idx 0, first=last=1, rtntype 4'h4.
- **CWF, macro defined.** Stimulus: first_beat=5. Expected: idx sequence 5,6,7,0,1,2,3,4; last at idx 4. **Macro undefined:** idx sequence 0..7.
- **Reset mid-response.** Stimulus: `rst_n` pulsed low after beat 3 of 8. Expected: `beat_val`=0 and `occupancy`=0 immediately; no remaining beats appear; a new response afterwards starts at idx 0.

Source files
------------

// File: rtl/l15_resp_ser_pkg.sv
// Shared definitions for the L1.5 response serializer: default geometry,
// derived beat widths, the default entry layout and parameter legality check.
package l15_resp_ser_pkg;

  localparam int LINE_BYTES_DEF = 64;
  localparam int BEAT_BITS_DEF  = 64;
  localparam int FIFO_DEPTH_DEF = 2;

  function automatic int calc_num_beats(input int line_bytes, input int beat_bits);
    return (line_bytes * 8) / beat_bits;
  endfunction

  function automatic int calc_beat_idx_w(input int num_beats);
    return (num_beats > 1) ? $clog2(num_beats) : 1;
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Line must split into a power-of-two number of whole beats; FIFO depth
  // must be a power of two of at least 2 so the wrap-bit pointers work.
  function automatic bit params_legal(input int line_bytes, input int beat_bits,
                                      input int fifo_depth);
    if (line_bytes <= 0 || beat_bits <= 0) return 1'b0;
    if (((line_bytes * 8) % beat_bits) != 0) return 1'b0;
    if (!is_pow2(calc_num_beats(line_bytes, beat_bits))) return 1'b0;
    if (!is_pow2(fifo_depth) || fifo_depth < 2) return 1'b0;
    return 1'b1;
  endfunction

  localparam int NUM_BEATS  = calc_num_beats(LINE_BYTES_DEF, BEAT_BITS_DEF);
  localparam int BEAT_IDX_W = calc_beat_idx_w(NUM_BEATS);

  // Entry layout for the default geometry.
  typedef struct packed {
    logic [3:0]                  rtntype;
    logic                        threadid;
    logic                        multi;
    logic [BEAT_IDX_W-1:0]       first_beat;
    logic [LINE_BYTES_DEF*8-1:0] data;
  } l15_resp_entry_t;

endpackage

// File: rtl/l15_resp_ser_fifo.sv
// Synchronous FIFO with wrap-bit pointers; holds whole response entries.
// Storage is not reset, only the pointers are.
module l15_resp_ser_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign occupancy = wr_ptr - rd_ptr;
  assign rd_data   = mem[rd_ptr[AW-1:0]];

  // Pointer advance; pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage write at the tail.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/l15_resp_serializer.sv
// L1.5 response serializer: buffers whole line responses and replays each as
// BEAT_BITS-wide beats over a valid/ready channel.
// Optional macro L15_RESP_SER_CWF_EN enables critical-word-first beat order.
module l15_resp_serializer
  import l15_resp_ser_pkg::*;
#(
  parameter  int LINE_BYTES = 64,
  parameter  int BEAT_BITS  = 64,
  parameter  int FIFO_DEPTH = 2,
  localparam int NB         = calc_num_beats(LINE_BYTES, BEAT_BITS),
  localparam int IDX_W      = calc_beat_idx_w(NB)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          l15_resp_val,
  input  logic [3:0]                    l15_resp_rtntype,
  input  logic                          l15_resp_threadid,
  input  logic                          l15_resp_multi,
  input  logic [IDX_W-1:0]              l15_resp_first_beat,
  input  logic [LINE_BYTES*8-1:0]       l15_resp_data,
  output logic                          l15_resp_ack,
  output logic                          beat_val,
  input  logic                          beat_rdy,
  output logic [BEAT_BITS-1:0]          beat_data,
  output logic [IDX_W-1:0]              beat_idx,
  output logic                          beat_first,
  output logic                          beat_last,
  output logic [3:0]                    beat_rtntype,
  output logic                          beat_threadid,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int LINE_BITS = LINE_BYTES * 8;

  if (!params_legal(LINE_BYTES, BEAT_BITS, FIFO_DEPTH)) begin : g_bad_params
    $error("l15_resp_serializer: illegal LINE_BYTES/BEAT_BITS/FIFO_DEPTH combination");
  end

  typedef struct packed {
    logic [3:0]           rtntype;
    logic                 threadid;
    logic                 multi;
`ifdef L15_RESP_SER_CWF_EN
    logic [IDX_W-1:0]     first_beat;
`endif
    logic [LINE_BITS-1:0] data;
  } entry_t;

  entry_t                 wr_entry;
  entry_t                 head;
  logic [$bits(entry_t)-1:0] head_bits;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   hs;
  logic                   at_last;
  logic [IDX_W-1:0]       cnt;
  logic [IDX_W-1:0]       last_cnt;
  logic [IDX_W-1:0]       line_idx;
  logic [BEAT_BITS-1:0]   sel_data;

  // Entry capture; the critical beat index is only kept when CWF is built in.
  always_comb begin
    wr_entry          = '0;
    wr_entry.rtntype  = l15_resp_rtntype;
    wr_entry.threadid = l15_resp_threadid;
    wr_entry.multi    = l15_resp_multi;
    wr_entry.data     = l15_resp_data;
`ifdef L15_RESP_SER_CWF_EN
    wr_entry.first_beat = l15_resp_first_beat;
`endif
  end

`ifndef L15_RESP_SER_CWF_EN
  logic unused_first_beat;
  assign unused_first_beat = ^l15_resp_first_beat;
`endif

  assign l15_resp_ack = l15_resp_val && !fifo_full;

  l15_resp_ser_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (l15_resp_ack),
    .wr_data   (wr_entry),
    .rd_en     (hs && at_last),
    .rd_data   (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  assign head     = entry_t'(head_bits);
  assign beat_val = !fifo_empty;
  assign hs       = beat_val && beat_rdy;
  assign last_cnt = head.multi ? IDX_W'(NB - 1) : '0;
  assign at_last  = (cnt == last_cnt);

  // Line position of the current beat: in order, or rotated from the
  // stored critical beat for full-line entries.
  always_comb begin
    line_idx = '0;
    if (head.multi) begin
`ifdef L15_RESP_SER_CWF_EN
      line_idx = (head.first_beat + cnt) & IDX_W'(NB - 1);
`else
      line_idx = cnt;
`endif
    end
  end

  assign sel_data = head.data[int'(line_idx)*BEAT_BITS +: BEAT_BITS];

  // Beat counter: advances per handshake, returns to 0 as the head pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hs) begin
      cnt <= at_last ? '0 : cnt + 1'b1;
    end
  end

  assign beat_data     = beat_val ? sel_data      : '0;
  assign beat_idx      = beat_val ? line_idx      : '0;
  assign beat_first    = beat_val && (cnt == '0);
  assign beat_last     = beat_val && at_last;
  assign beat_rtntype  = beat_val ? head.rtntype  : '0;
  assign beat_threadid = beat_val && head.threadid;

endmodule

// File: tb/tb_l15_resp_serializer.sv
// Scoreboard bench for l15_resp_serializer (default geometry: 8 beats of 64b).
module tb_l15_resp_serializer;

  localparam int NB = 8;
`ifdef L15_RESP_SER_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         l15_resp_val;
  logic [3:0]   l15_resp_rtntype;
  logic         l15_resp_threadid;
  logic         l15_resp_multi;
  logic [2:0]   l15_resp_first_beat;
  logic [511:0] l15_resp_data;
  logic         l15_resp_ack;
  logic         beat_val;
  logic         beat_rdy;
  logic [63:0]  beat_data;
  logic [2:0]   beat_idx;
  logic         beat_first;
  logic         beat_last;
  logic [3:0]   beat_rtntype;
  logic         beat_threadid;
  logic [1:0]   occupancy;

  l15_resp_serializer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .l15_resp_val        (l15_resp_val),
    .l15_resp_rtntype    (l15_resp_rtntype),
    .l15_resp_threadid   (l15_resp_threadid),
    .l15_resp_multi      (l15_resp_multi),
    .l15_resp_first_beat (l15_resp_first_beat),
    .l15_resp_data       (l15_resp_data),
    .l15_resp_ack        (l15_resp_ack),
    .beat_val            (beat_val),
    .beat_rdy            (beat_rdy),
    .beat_data           (beat_data),
    .beat_idx            (beat_idx),
    .beat_first          (beat_first),
    .beat_last           (beat_last),
    .beat_rtntype        (beat_rtntype),
    .beat_threadid       (beat_threadid),
    .occupancy           (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  idx;
    bit          first;
    bit          last;
    logic [3:0]  rt;
    bit          tid;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   hs_cnt      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a response expands into its beat list from the line
  // geometry and ordering rule alone.
  always @(negedge clk) begin
    if (rst_n && l15_resp_val && l15_resp_ack) begin
      int n;
      n = l15_resp_multi ? NB : 1;
      for (int k = 0; k < n; k++) begin
        exp_t e;
        int   idx;
        if (!l15_resp_multi)  idx = 0;
        else if (CWF)         idx = (int'(l15_resp_first_beat) + k) % NB;
        else                  idx = k;
        e.data  = l15_resp_data[idx*64 +: 64];
        e.idx   = 3'(idx);
        e.first = (k == 0);
        e.last  = (k == n - 1);
        e.rt    = l15_resp_rtntype;
        e.tid   = l15_resp_threadid;
        sb.push_back(e);
      end
    end
  end

  // Monitor: compares every handshaked beat and checks stall stability.
  logic        stalled = 1'b0;
  logic [63:0] held_data;
  logic [9:0]  held_meta;
  always @(negedge clk) begin
    logic [9:0] meta;
    meta = {beat_idx, beat_first, beat_last, beat_rtntype, beat_threadid};
    if (rst_n && beat_val) begin
      if (stalled) begin
        check("stall_data", beat_data, held_data);
        check("stall_fields", 64'(meta), 64'(held_meta));
      end
      if (beat_rdy) begin
        hs_cnt++;
        stalled = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("beat_data", beat_data, e.data);
          check("beat_idx", 64'(beat_idx), 64'(e.idx));
          check("beat_first", 64'(beat_first), 64'(e.first));
          check("beat_last", 64'(beat_last), 64'(e.last));
          check("beat_rtntype", 64'(beat_rtntype), 64'(e.rt));
          check("beat_threadid", 64'(beat_threadid), 64'(e.tid));
        end
      end else begin
        stalled   = 1'b1;
        held_data = beat_data;
        held_meta = meta;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic drive(input bit multi, input logic [2:0] fb, input logic [3:0] rt,
                       input bit tid, input logic [511:0] data);
    l15_resp_val        = 1'b1;
    l15_resp_multi      = multi;
    l15_resp_first_beat = fb;
    l15_resp_rtntype    = rt;
    l15_resp_threadid   = tid;
    l15_resp_data       = data;
  endtask

  task automatic wait_ack();
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = l15_resp_ack;
    end
    if (!got) check("ack_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 l15_resp_val = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !beat_val;
    end
    if (!done) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] line;
    logic [3:0]   pat;
    int           base;
    bit           rand_done;

    rst_n = 1'b0;  beat_rdy = 1'b1;
    l15_resp_val = 1'b0; l15_resp_rtntype = '0; l15_resp_threadid = 1'b0;
    l15_resp_multi = 1'b0; l15_resp_first_beat = '0; l15_resp_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 l15_resp_val = 1'b1;
    @(negedge clk);
    check("rst_beat_val", 64'(beat_val), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_ack_follows_val", 64'(l15_resp_ack), 64'd1);
    check("rst_beat_data", beat_data, 64'd0);
    @(posedge clk);
    #1 l15_resp_val = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One line response, beat k = 0x1111111111111111*k, continuous ready
    for (int k = 0; k < NB; k++) line[k*64 +: 64] = 64'h1111_1111_1111_1111 * k;
    drive(1'b1, 3'd0, 4'h1, 1'b0, line);
    wait_ack();
    check("latency_beat_val", 64'(beat_val), 64'd1);
    check("latency_first", 64'(beat_first), 64'd1);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      check("line_continuous", 64'(beat_val), 64'd1);
    end
    @(negedge clk);
    check("line_done_val", 64'(beat_val), 64'd0);
    drain();

    // Back-pressure: ready pattern 1,0,0,1
    pat = 4'b1001;
    base = hs_cnt;
    drive(1'b1, 3'd2, 4'h2, 1'b1, rand_line());
    wait_ack();
    for (int i = 0; i < 40 && beat_val; i++) begin
      beat_rdy = pat[3 - (i % 4)];
      @(posedge clk); #1;
    end
    beat_rdy = 1'b1;
    drain();
    check("bp_handshakes", 64'(hs_cnt - base), 64'd8);

    // Full FIFO: two accepted, third held until the head pops
    beat_rdy = 1'b0;
    drive(1'b1, 3'd1, 4'h3, 1'b0, rand_line());
    wait_ack();
    drive(1'b1, 3'd3, 4'h5, 1'b1, rand_line());
    wait_ack();
    drive(1'b1, 3'd6, 4'h6, 1'b0, rand_line());
    @(negedge clk);
    check("full_occupancy", 64'(occupancy), 64'd2);
    check("full_ack_blocked", 64'(l15_resp_ack), 64'd0);
    @(posedge clk);
    #1 beat_rdy = 1'b1;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      check("full_hold_ack", 64'(l15_resp_ack), 64'd0);
    end
    @(negedge clk);
    check("full_ack_after_pop", 64'(l15_resp_ack), 64'd1);
    check("b2b_no_bubble", 64'(beat_val), 64'd1);
    @(posedge clk);
    #1 l15_resp_val = 1'b0;
    drain();

    // Single-beat response
    base = hs_cnt;
    line = rand_line();
    line[63:0] = 64'h0000_0000_DEAD_BEEF;
    drive(1'b0, 3'd5, 4'h4, 1'b1, line);
    wait_ack();
    check("single_first_last", 64'({beat_first, beat_last}), 64'd3);
    drain();
    check("single_handshakes", 64'(hs_cnt - base), 64'd1);

    // Critical-word-first from beat 5 (in-order when the feature is absent)
    drive(1'b1, 3'd5, 4'h7, 1'b0, rand_line());
    wait_ack();
    check("cwf_start_idx", 64'(beat_idx), CWF ? 64'd5 : 64'd0);
    drain();

    // Reset mid-response after three beats
    base = hs_cnt;
    drive(1'b1, 3'd0, 4'h8, 1'b1, rand_line());
    wait_ack();
    for (int i = 0; i < 20 && (hs_cnt - base) < 3; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_beat_val", 64'(beat_val), 64'd0);
    check("midrst_occupancy", 64'(occupancy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = hs_cnt;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_beats", 64'(hs_cnt - base), 64'd0);
    drive(1'b1, 3'd0, 4'h9, 1'b0, rand_line());
    wait_ack();
    check("midrst_new_idx", 64'(beat_idx), 64'd0);
    check("midrst_new_first", 64'(beat_first), 64'd1);
    drain();

    // Randomized traffic with random ready
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, rand_line());
          wait_ack();
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        rand_done = 1'b1;
      end
      begin
        for (int c = 0; c < 3000 && !rand_done; c++) begin
          @(posedge clk);
          #1 beat_rdy = ($urandom_range(0, 3) != 0);
        end
        beat_rdy = 1'b1;
      end
    join
    beat_rdy = 1'b1;
    drain();
    check("final_occupancy", 64'(occupancy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
